// File: rtl/xnor_match_tracker.sv
// Tracks per-bit XNOR equality of two serial streams. It keeps a consecutive-match run
// length and a mismatch total, and a lock FSM that tolerates a single miss while locked.
module xnor_match_tracker #(
   parameter int LOCK_LEN = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   output logic             match,
   output logic             match_valid,
   output logic [CNT_W-1:0] run_len,
   output logic [CNT_W-1:0] err_cnt,
   output logic             locked
);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_LOCKED = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;

   localparam logic [CNT_W:0] LOCK_THR = (CNT_W+1)'(LOCK_LEN);

   logic [1:0]       state_q, state_d;
   logic             match_q, match_d;
   logic             match_valid_q, match_valid_d;
   logic [CNT_W-1:0] run_len_q, run_len_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             m;
   logic [CNT_W:0]   run_sum;
   logic [CNT_W:0]   err_sum;

   assign m = ~(a ^ b);

   // Sums are one bit wider so saturation and the lock threshold both see the true count.
   assign run_sum = {1'b0, run_len_q} + (CNT_W+1)'(1);
   assign err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(1);

   always_comb begin
      state_d       = state_q;
      match_d       = match_q;
      match_valid_d = 1'b0;
      run_len_d     = run_len_q;
      err_cnt_d     = err_cnt_q;
      if (in_valid) begin
         match_d       = m;
         match_valid_d = 1'b1;
         if (m) begin
            run_len_d = run_sum[CNT_W] ? {CNT_W{1'b1}} : run_sum[CNT_W-1:0];
         end else begin
            run_len_d = '0;
            err_cnt_d = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
         end
         case (state_q)
            S_SEARCH: if (m && (run_sum >= LOCK_THR)) state_d = S_LOCKED;
            S_LOCKED: if (!m) state_d = S_CHECK;
            S_CHECK:  state_d = m ? S_LOCKED : S_SEARCH;
            default:  state_d = S_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q       <= S_SEARCH;
         match_q       <= 1'b0;
         match_valid_q <= 1'b0;
         run_len_q     <= '0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         match_q       <= match_d;
         match_valid_q <= match_valid_d;
         run_len_q     <= run_len_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign match       = match_q;
   assign match_valid = match_valid_q;
   assign run_len     = run_len_q;
   assign err_cnt     = err_cnt_q;
   assign locked      = (state_q != S_SEARCH);

endmodule

// File: tb/tb_xnor_match_tracker.sv
// Directed and randomized checks of xnor_match_tracker against a behavioural model,
// using a default instance (CNT_W=8, LOCK_LEN=8) and a small one (CNT_W=4, LOCK_LEN=3).
module tb_xnor_match_tracker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       clr [2];
   logic       vld [2];
   logic       ain [2];
   logic       bin [2];

   logic       mt0, mv0, lk0;
   logic [7:0] rl0, ec0;
   logic       mt1, mv1, lk1;
   logic [3:0] rl1, ec1;

   xnor_match_tracker #(.LOCK_LEN(8), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(vld[0]), .a(ain[0]), .b(bin[0]),
      .match(mt0), .match_valid(mv0), .run_len(rl0), .err_cnt(ec0), .locked(lk0));

   xnor_match_tracker #(.LOCK_LEN(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(vld[1]), .a(ain[1]), .b(bin[1]),
      .match(mt1), .match_valid(mv1), .run_len(rl1), .err_cnt(ec1), .locked(lk1));

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: plain counts plus "locked" and "one miss already taken" flags.
   int  m_run [2];
   int  m_err [2];
   bit  m_lock[2];
   bit  m_miss[2];
   bit  m_mt  [2];
   bit  m_mv  [2];
   int  m_max [2] = '{255, 15};
   int  m_thr [2] = '{8, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input int id);
      if (!rst_n || clr[id]) begin
         m_run[id] = 0; m_err[id] = 0; m_lock[id] = 0; m_miss[id] = 0;
         m_mt[id] = 0; m_mv[id] = 0;
      end else if (vld[id]) begin
         m_mv[id] = 1;
         m_mt[id] = (ain[id] == bin[id]);
         if (m_mt[id]) begin
            if (!m_lock[id] && m_run[id] + 1 >= m_thr[id]) m_lock[id] = 1;
            m_miss[id] = 0;
            m_run[id] = (m_run[id] + 1 > m_max[id]) ? m_max[id] : m_run[id] + 1;
         end else begin
            m_run[id] = 0;
            m_err[id] = (m_err[id] + 1 > m_max[id]) ? m_max[id] : m_err[id] + 1;
            if (m_lock[id]) begin
               if (m_miss[id]) begin m_lock[id] = 0; m_miss[id] = 0; end
               else m_miss[id] = 1;
            end
         end
      end else begin
         m_mv[id] = 0;
      end
   endtask

   task automatic check_all();
      chk("d0.match",   32'(mt0), 32'(m_mt[0]));
      chk("d0.mvalid",  32'(mv0), 32'(m_mv[0]));
      chk("d0.run_len", 32'(rl0), 32'(m_run[0]));
      chk("d0.err_cnt", 32'(ec0), 32'(m_err[0]));
      chk("d0.locked",  32'(lk0), 32'(m_lock[0]));
      chk("d1.match",   32'(mt1), 32'(m_mt[1]));
      chk("d1.mvalid",  32'(mv1), 32'(m_mv[1]));
      chk("d1.run_len", 32'(rl1), 32'(m_run[1]));
      chk("d1.err_cnt", 32'(ec1), 32'(m_err[1]));
      chk("d1.locked",  32'(lk1), 32'(m_lock[1]));
   endtask

   // One clock: drive instance id, keep the other idle, then advance and check both.
   task automatic step(input int id, input bit c, input bit v, input bit a, input bit b);
      clr[id] = c; vld[id] = v; ain[id] = a; bin[id] = b;
      clr[1-id] = 1'b0; vld[1-id] = 1'b0;
      ain[1-id] = 1'($urandom); bin[1-id] = 1'($urandom);
      @(posedge clk);
      model(0);
      model(1);
      #1;
      check_all();
   endtask

   task automatic match_s(input int id);
      bit x;
      x = 1'($urandom);
      step(id, 1'b0, 1'b1, x, x);
   endtask

   task automatic miss_s(input int id);
      bit x;
      x = 1'($urandom);
      step(id, 1'b0, 1'b1, x, ~x);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         clr[i] = 1'b0; vld[i] = 1'b0; ain[i] = 1'b0; bin[i] = 1'b0;
      end

      // Reset held with random activity on both instances.
      for (int i = 0; i < 2; i++) begin
         clr[0] = 1'($urandom); clr[1] = 1'($urandom);
         vld[0] = 1'($urandom); vld[1] = 1'($urandom);
         ain[0] = 1'($urandom); bin[0] = 1'($urandom);
         ain[1] = 1'($urandom); bin[1] = 1'($urandom);
         @(posedge clk);
         model(0); model(1);
         #1;
         check_all();
      end
      chk("reset.locked", 32'(lk0), 32'd0);
      chk("reset.err",    32'(ec0), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle.mvalid", 32'(mv0), 32'd0);

      // Lock acquisition on the default instance.
      for (int i = 1; i <= 8; i++) begin
         match_s(0);
         chk("acq.run_len", 32'(rl0), 32'(i));
         chk("acq.locked",  32'(lk0), 32'(i == 8));
         chk("acq.mvalid",  32'(mv0), 32'd1);
      end
      chk("acq.err", 32'(ec0), 32'd0);

      // Single miss is tolerated.
      step(0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("tol.locked", 32'(lk0), 32'd1);
      chk("tol.run",    32'(rl0), 32'd0);
      chk("tol.err",    32'(ec0), 32'd1);
      match_s(0);
      chk("tol.relock", 32'(lk0), 32'd1);
      chk("tol.run1",   32'(rl0), 32'd1);

      // Two misses drop lock; relock needs eight fresh matches.
      miss_s(0);
      miss_s(0);
      chk("loss.locked", 32'(lk0), 32'd0);
      chk("loss.err",    32'(ec0), 32'd3);
      for (int i = 1; i <= 8; i++) begin
         match_s(0);
         chk("relock.locked", 32'(lk0), 32'(i == 8));
      end

      // Clear, then a lock sequence with idle gaps.
      step(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("clr.locked", 32'(lk0), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         match_s(0);
         chk("gap.locked", 32'(lk0), 32'(i == 8));
         for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
            step(0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
            chk("gap.mvalid", 32'(mv0), 32'd0);
            chk("gap.run",    32'(rl0), 32'(i));
         end
      end
      step(0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("clrv.err",    32'(ec0), 32'd0);
      chk("clrv.locked", 32'(lk0), 32'd0);
      chk("clrv.mvalid", 32'(mv0), 32'd0);

      // Saturation on the narrow instance.
      for (int i = 0; i < 20; i++) miss_s(1);
      chk("sat.err", 32'(ec1), 32'd15);
      for (int i = 0; i < 20; i++) match_s(1);
      chk("sat.run",    32'(rl1), 32'd15);
      chk("sat.locked", 32'(lk1), 32'd1);
      miss_s(1);
      chk("sat.run0",   32'(rl1), 32'd0);
      chk("sat.err15",  32'(ec1), 32'd15);
      chk("sat.check",  32'(lk1), 32'd1);

      // Random traffic, biased toward matches so both instances lock and unlock.
      for (int i = 0; i < 600; i++) begin
         bit x, mm, v, c;
         x  = 1'($urandom);
         mm = ($urandom_range(99) < 80);
         v  = ($urandom_range(99) < 75);
         c  = ($urandom_range(99) < 2);
         step(i % 2, c, v, x, mm ? x : ~x);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
